// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the memory-port arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / REQ / RESP)
//   arb_owner_t : which requester owns the in-flight transaction
//   WSTRB_*     : access-width codes carried on d_wstrb / mem_wstrb
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  localparam logic [1:0] WSTRB_BYTE = 2'd0;
  localparam logic [1:0] WSTRB_HALF = 2'd1;
  localparam logic [1:0] WSTRB_WORD = 2'd2;

endpackage

// File: rtl/mem_arbiter_arb_priority.sv
// arb_priority: fixed D-over-I winner select with a starvation guard for I.
// Ports:
//   clock, reset : system clock, async active-high reset
//   arb_en       : arbitration is live this cycle (arbiter idle)
//   i_req, d_req : pending requests
//   pick_i/pick_d: combinational winner (at most one high)
// starve_cnt counts consecutive D wins while I waits; once it reaches
// STARVE_LIMIT the next arbitration with I pending goes to I.
module arb_priority
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic pick_i,
  output logic pick_d
);

  logic [3:0] starve_cnt;
  logic       i_forced;

  always_comb begin
    i_forced = i_req && (starve_cnt == 4'(STARVE_LIMIT));
    pick_d   = d_req && !i_forced;
    pick_i   = i_req && !pick_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (arb_en && (pick_i || pick_d)) begin
      if (pick_d && i_req) begin
        if (starve_cnt != '1) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between instruction fetch
// (port I) and load/store (port D). One outstanding transaction at a time;
// D has priority, with a starvation guard for I (see arb_priority).
// Ports:
//   clock, reset                : clock, async active-high reset
//   i_req/i_addr -> i_gnt        : fetch request / 1-cycle accept pulse
//   i_rvalid/i_rdata             : fetch response pulse and held data
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> d_gnt : data request / accept
//   d_rvalid/d_rdata             : load data or store ack (rdata 0 on stores)
//   mem_req + mem_we/addr/wdata/wstrb : latched downstream request
//   mem_gnt, mem_rvalid, mem_rdata    : downstream accept and response
// Optional: define MEM_ARB_PERF_EN to add perf_i_grants, perf_d_grants and
// perf_stall_cycles (32-bit wrapping counters).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_stall_cycles
`endif
);

  arb_state_t state;
  arb_owner_t owner;
  logic       idle;
  logic       pick_i;
  logic       pick_d;

  assign idle = (state == IDLE);

  arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .clock (clock),
    .reset (reset),
    .arb_en(idle),
    .i_req (i_req),
    .d_req (d_req),
    .pick_i(pick_i),
    .pick_d(pick_d)
  );

  // Grants are combinational; held low during reset so every output is 0.
  assign i_gnt   = idle && !reset && pick_i;
  assign d_gnt   = idle && !reset && pick_d;
  assign mem_req = (state == REQ);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWNER_I;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            owner     <= OWNER_D;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wstrb;
            state     <= REQ;
          end else if (pick_i) begin
            owner     <= OWNER_I;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wstrb <= WSTRB_WORD;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) state <= RESP;
        end
        RESP: begin
          if (mem_rvalid) begin
            state <= IDLE;
            if (owner == OWNER_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_we ? '0 : mem_rdata;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_i_grants     <= '0;
      perf_d_grants     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (i_gnt) perf_i_grants <= perf_i_grants + 32'd1;
      if (d_gnt) perf_d_grants <= perf_d_grants + 32'd1;
      if ((i_req || d_req) && !(i_gnt || d_gnt))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (directed scenarios
// plus a randomized run against a transaction-level reference model).
// Define MEM_ARB_PERF_EN to also check the performance counters.
module tb_mem_arbiter;

  localparam int LIM = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_gnt, mem_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]  d_wstrb;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_wstrb;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [135:0] all_outs;
  assign all_outs = {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb};

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  task automatic idle_inputs();
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    idle_inputs();
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outs: got %h expected 0", all_outs);
    end
    i_req = 1; d_req = 1;
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_gnt_blocked: got %h expected 0", all_outs);
    end
    @(negedge clock);
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_single_fetch();
    do_reset();
    @(negedge clock); i_req = 1; i_addr = 32'h100; #1;
    n_checks++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL fetch_gnt: got %b expected 10", {i_gnt, d_gnt});
    end
    @(negedge clock); i_req = 0; mem_gnt = 1; #1;
    n_checks++;
    if ({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 1'b0, 2'd2, 32'h100, 32'h0}) begin
      n_fail++; $display("FAIL fetch_fields: got %b %b %0d %h %h expected 1 0 2 100 0",
                         mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata);
    end
    @(negedge clock); mem_gnt = 0; #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL fetch_req_drop: got %b expected 0", mem_req);
    end
    @(negedge clock); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
    n_checks++;
    if ({i_rvalid, d_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_early_rvalid: got %b expected 00", {i_rvalid, d_rvalid});
    end
    @(negedge clock); mem_rvalid = 0; #1;
    n_checks++;
    if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL fetch_resp: got %b %b %h expected 1 0 deadbeef", i_rvalid, d_rvalid, i_rdata);
    end
    @(negedge clock); #1;
    n_checks++;
    if ({i_rvalid, d_rvalid, i_rdata} !== {2'b00, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL fetch_hold: got %b %b %h expected 0 0 deadbeef", i_rvalid, d_rvalid, i_rdata);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    @(negedge clock);
    i_req = 1; i_addr = 32'h100;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wstrb = 2'd2;
    #1;
    n_checks++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL sim_gnt: got %b expected 01", {i_gnt, d_gnt});
    end
    @(negedge clock); d_req = 0; mem_gnt = 1; #1;
    n_checks++;
    if ({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, i_gnt} !==
        {1'b1, 1'b1, 2'd2, 32'h200, 32'h12345678, 1'b0}) begin
      n_fail++; $display("FAIL sim_store_fields: got %b %b %0d %h %h %b", mem_req, mem_we,
                         mem_wstrb, mem_addr, mem_wdata, i_gnt);
    end
    @(negedge clock); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; #1;
    @(negedge clock); mem_rvalid = 0; #1;
    n_checks++;
    if ({d_rvalid, d_rdata, i_rvalid, i_gnt} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL sim_store_ack: got %b %h %b %b expected 1 0 0 1",
                         d_rvalid, d_rdata, i_rvalid, i_gnt);
    end
    @(negedge clock); i_req = 0; mem_gnt = 1; #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, 32'h100, 2'd2}) begin
      n_fail++; $display("FAIL sim_fetch_fields: got %b %b %h %0d", mem_req, mem_we, mem_addr, mem_wstrb);
    end
    @(negedge clock); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
    @(negedge clock); mem_rvalid = 0; #1;
    n_checks++;
    if ({i_rvalid, i_rdata, d_rvalid} !== {1'b1, 32'h0BADF00D, 1'b0}) begin
      n_fail++; $display("FAIL sim_fetch_resp: got %b %h %b", i_rvalid, i_rdata, d_rvalid);
    end
  endtask

  task automatic test_starvation();
    logic [5:0] got;
    int         n;
    got = '0; n = 0;
    do_reset();
    @(negedge clock);
    i_req = 1; d_req = 1; d_we = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = $urandom;
    for (int c = 0; c < 40 && n < 6; c++) begin
      #1;
      if (i_gnt || d_gnt) begin
        got = {got[4:0], d_gnt};
        n++;
      end
      @(negedge clock);
    end
    n_checks++;
    if (n != 6 || got !== 6'b111101) begin
      n_fail++; $display("FAIL starve_order: got %0d grants order %b expected 6 grants 111101", n, got);
    end
    idle_inputs();
  endtask

  task automatic test_gnt_delay();
    do_reset();
    @(negedge clock);
    d_req = 1; d_we = 0; d_addr = 32'h300; d_wdata = 32'h55; d_wstrb = 2'd1; #1;
    n_checks++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL delay_gnt: got %b expected 01", {i_gnt, d_gnt});
    end
    @(negedge clock); d_req = 0; i_req = 1; i_addr = 32'h400;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) mem_gnt = 1;
      #1;
      n_checks++;
      if ({mem_req, i_gnt, d_gnt, mem_we, mem_wstrb, mem_addr, mem_wdata} !==
          {3'b100, 1'b0, 2'd1, 32'h300, 32'h55}) begin
        n_fail++; $display("FAIL delay_hold: cycle %0d got %b%b%b %b %0d %h %h", c, mem_req,
                           i_gnt, d_gnt, mem_we, mem_wstrb, mem_addr, mem_wdata);
      end
      @(negedge clock);
    end
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_0001;
    @(negedge clock); mem_rvalid = 0; #1;
    n_checks++;
    if ({d_rvalid, d_rdata, i_gnt} !== {1'b1, 32'hA5A5_0001, 1'b1}) begin
      n_fail++; $display("FAIL delay_load_resp: got %b %h %b expected 1 a5a50001 1", d_rvalid, d_rdata, i_gnt);
    end
    @(negedge clock); idle_inputs();
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    @(negedge clock); i_req = 1; i_addr = 32'h500;
    @(negedge clock); i_req = 0; mem_gnt = 1;
    @(negedge clock); mem_gnt = 0;
    #2 reset = 1;
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL resp_reset_outs: got %h expected 0", all_outs);
    end
    @(negedge clock); reset = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (all_outs !== '0) begin
        n_fail++; $display("FAIL stale_rvalid: cycle %0d got %h expected 0", c, all_outs);
      end
      @(negedge clock);
    end
    mem_rvalid = 0; i_req = 1; i_addr = 32'h600; #1;
    n_checks++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL post_reset_gnt: got %b expected 10", {i_gnt, d_gnt});
    end
    @(negedge clock); idle_inputs();
  endtask

  // Randomized traffic against a transaction-level model: the model only
  // tracks whether the port is free, waiting for accept, or waiting for
  // data, plus the starvation count and the fields of the last grant.
  task automatic test_random();
    int          phase, starve, gdly, rdly;
    logic        own_d, m_we, pulse_i, pulse_d, eg_i, eg_d, last_gi, last_gd;
    logic [1:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
    int unsigned pi, pd, ps;
    phase = 0; starve = 0; gdly = 0; rdly = 0; own_d = 0; m_we = 0;
    pulse_i = 0; pulse_d = 0; last_gi = 0; last_gd = 0;
    m_wstrb = '0; m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
    pi = 0; pd = 0; ps = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      if (last_gi || !i_req) begin
        i_req = ($urandom_range(0, 3) != 0); i_addr = $urandom;
      end else if ($urandom_range(0, 15) == 0) i_req = 0;
      if (last_gd || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = 1'($urandom);
        d_addr = $urandom; d_wdata = $urandom; d_wstrb = 2'($urandom_range(0, 2));
      end else if ($urandom_range(0, 15) == 0) d_req = 0;
      mem_rdata = $urandom;
      if (phase == 1) begin
        mem_gnt = (gdly == 0);
        if (gdly != 0) gdly--;
      end else mem_gnt = ($urandom_range(0, 7) == 0);
      if (phase == 2) begin
        mem_rvalid = (rdly == 0);
        if (rdly != 0) rdly--;
      end else mem_rvalid = ($urandom_range(0, 7) == 0);
      #1;
      eg_d = (phase == 0) && d_req && !(i_req && starve == LIM);
      eg_i = (phase == 0) && i_req && !eg_d;
      n_checks++;
      if ({i_gnt, d_gnt, mem_req, i_rvalid, d_rvalid} !== {eg_i, eg_d, phase == 1, pulse_i, pulse_d}) begin
        n_fail++; $display("FAIL rand_ctrl: cycle %0d got %b expected %b", cyc,
                           {i_gnt, d_gnt, mem_req, i_rvalid, d_rvalid},
                           {eg_i, eg_d, phase == 1, pulse_i, pulse_d});
      end
      n_checks++;
      if ({mem_we, mem_wstrb, mem_addr, mem_wdata} !== {m_we, m_wstrb, m_addr, m_wdata}) begin
        n_fail++; $display("FAIL rand_fields: cycle %0d got %b %0d %h %h expected %b %0d %h %h", cyc,
                           mem_we, mem_wstrb, mem_addr, mem_wdata, m_we, m_wstrb, m_addr, m_wdata);
      end
      n_checks++;
      if ({i_rdata, d_rdata} !== {m_irdata, m_drdata}) begin
        n_fail++; $display("FAIL rand_rdata: cycle %0d got %h %h expected %h %h", cyc,
                           i_rdata, d_rdata, m_irdata, m_drdata);
      end
      if (eg_i) pi++;
      if (eg_d) pd++;
      if ((i_req || d_req) && !eg_i && !eg_d) ps++;
      pulse_i = 0; pulse_d = 0;
      if (phase == 0 && (eg_i || eg_d)) begin
        own_d   = eg_d;
        m_we    = eg_d ? d_we : 1'b0;
        m_addr  = eg_d ? d_addr : i_addr;
        m_wdata = eg_d ? d_wdata : 32'h0;
        m_wstrb = eg_d ? d_wstrb : 2'd2;
        starve  = (eg_d && i_req) ? ((starve < 15) ? starve + 1 : 15) : 0;
        phase   = 1;
        gdly    = $urandom_range(0, 3);
      end else if (phase == 1 && mem_gnt) begin
        phase = 2;
        rdly  = $urandom_range(0, 3);
      end else if (phase == 2 && mem_rvalid) begin
        phase = 0;
        if (own_d) begin
          pulse_d  = 1;
          m_drdata = m_we ? 32'h0 : mem_rdata;
        end else begin
          pulse_i  = 1;
          m_irdata = mem_rdata;
        end
      end
      last_gi = eg_i; last_gd = eg_d;
    end
    @(negedge clock);
    idle_inputs();
    #1;
`ifdef MEM_ARB_PERF_EN
    n_checks++;
    if ({perf_i_grants, perf_d_grants, perf_stall_cycles} !== {pi, pd, ps}) begin
      n_fail++; $display("FAIL perf_counters: got %0d %0d %0d expected %0d %0d %0d",
                         perf_i_grants, perf_d_grants, perf_stall_cycles, pi, pd, ps);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_gnt_delay();
    test_reset_in_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external memory port between two requesters: instruction fetch (port I) and load/store data access (port D).
- Sits between the cpu core's fetch/memory-access stages and the memory model.
- Serialises requests, one outstanding transaction at a time.
- Priority is fixed with D over I, plus a starvation guard for I. Responses are routed back to the owning requester.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, number of consecutive D grants allowed while I is pending before I is forced; range 1..15

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, held until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted (1-cycle pulse)
- i_rvalid  out  1  fetch data valid (1-cycle pulse)
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  2  access width: 0 = byte, 1 = half, 2 = word
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  load data / store acknowledge (1-cycle pulse)
- d_rdata  out  DATA_W  load data; 0 for stores
- mem_req  out  1  downstream request, held until mem_gnt
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/2  latched request fields
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  memory response (reads and writes)
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset is async, active-high. State = IDLE, starve_cnt = 0. All outputs 0, including latched fields. Any in-flight transaction is dropped; a mem_rvalid arriving after reset deasserts is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE, arbitration (combinational):
  - Pick D if d_req and not (i_req and starve_cnt == STARVE_LIMIT); else pick I if i_req.
  - The winner's gnt is asserted combinationally this cycle. Fields are latched into mem_* and owner is recorded.
  - Next state is REQ. With no request, stay in IDLE.
- I requests always latch mem_we = 0, mem_wstrb = 2, mem_wdata = 0.
- starve_cnt update, on a grant in IDLE:
  - D granted while i_req: +1, saturating.
  - Otherwise (I granted, or D granted with no i_req): cleared to 0.
- REQ: mem_req = 1 with stable fields. On mem_gnt go to RESP; mem_req drops the next cycle.
- RESP: wait for mem_rvalid. On mem_rvalid, register rdata and pulse the owner's rvalid on the next cycle; d_rdata is forced to 0 if owner was a store. Then go to IDLE.
  - IDLE may grant again in that same cycle the rvalid pulse appears.
- Minimum latency: gnt at cycle 0, mem_req at cycle 1, mem_rvalid at cycle 2 at earliest, upstream rvalid at cycle 3.
- mem_rvalid in IDLE or REQ is ignored. mem_gnt outside REQ is ignored.
- Upstream rdata holds its last value between pulses.
- A requester dropping req before gnt is legal; nothing is issued for it.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds outputs perf_i_grants (32), perf_d_grants (32) and perf_stall_cycles (32).
  - perf_stall_cycles counts cycles where any req is high and no gnt is issued.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package common gains:
  - arb_state_t enum {IDLE, REQ, RESP}
  - arb_owner_t enum {OWNER_I, OWNER_D}
  - constants WSTRB_BYTE = 0, WSTRB_HALF = 1, WSTRB_WORD = 2
- One sub-module, arb_priority: combinational winner select plus the registered starve_cnt. mem_arbiter instantiates it once.

Test Plan:
- Single fetch: i_req with i_addr = 0x100; memory returns 0xDEADBEEF 2 cycles after mem_gnt -> i_gnt at cycle 0, mem_addr = 0x100 with mem_we = 0, i_rvalid with i_rdata = 0xDEADBEEF, d_rvalid never asserted.
- Simultaneous i_req and d_req (store 0x12345678 to 0x200, wstrb = 2) -> d_gnt first, then d_rvalid with d_rdata = 0; i_gnt in the IDLE cycle after, mem_addr = 0x100.
- Starvation: i_req and d_req held high continuously, STARVE_LIMIT = 4 -> grant order D, D, D, D, I, D...
- mem_gnt delayed 5 cycles -> mem_req and fields stable for all 5 cycles; no second gnt issued meanwhile.
- Reset in RESP, then a stale mem_rvalid after reset release -> no i_rvalid/d_rvalid pulse, state IDLE, all outputs 0.
- MEM_ARB_PERF_EN defined: 3 fetches, 2 loads, 6 blocked-request cycles -> perf_i_grants = 3, perf_d_grants = 2, perf_stall_cycles = 6.
